// File: rtl/gpio_apb_gen2.sv
// APB GPIO: optional synchroniser, per-pin glitch filter, sticky edge/level interrupts, atomic output ops; zero wait states.
// Strap capture (registers 0x3C/0x40) is compiled in only when GPIO_STRAP_EN is defined.
module gpio_apb_gen2 #(
    parameter int NUM_PINS  = 32,
    parameter int CNT_WIDTH = 4,
    parameter int ASYNC_ON  = 1
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [7:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq,
    input  logic                strap_en,
    output logic                strap_valid,
    output logic [NUM_PINS-1:0] strap_data
);
    localparam int TH_MAX   = (1 << CNT_WIDTH) - 1;
    localparam int TH_RST_I = (TH_MAX < 4) ? TH_MAX : 4;
    localparam logic [CNT_WIDTH-1:0] TH_RST = TH_RST_I[CNT_WIDTH-1:0];

    localparam logic [5:0] A_DATA_IN    = 6'h00;
    localparam logic [5:0] A_DATA_OUT   = 6'h01;
    localparam logic [5:0] A_OUT_SET    = 6'h02;
    localparam logic [5:0] A_OUT_CLR    = 6'h03;
    localparam logic [5:0] A_OUT_TGL    = 6'h04;
    localparam logic [5:0] A_OE         = 6'h05;
    localparam logic [5:0] A_INTR_STATE = 6'h06;
    localparam logic [5:0] A_INTR_EN    = 6'h07;
    localparam logic [5:0] A_INTR_TEST  = 6'h08;
    localparam logic [5:0] A_RISE_EN    = 6'h09;
    localparam logic [5:0] A_FALL_EN    = 6'h0A;
    localparam logic [5:0] A_LVLHI_EN   = 6'h0B;
    localparam logic [5:0] A_LVLLO_EN   = 6'h0C;
    localparam logic [5:0] A_FILT_EN    = 6'h0D;
    localparam logic [5:0] A_FILT_TH    = 6'h0E;
`ifdef GPIO_STRAP_EN
    localparam logic [5:0] A_STRAP_CTRL = 6'h0F;
    localparam logic [5:0] A_STRAP_DATA = 6'h10;
`endif

    logic [NUM_PINS-1:0]  r_data_out;
    logic [NUM_PINS-1:0]  r_oe;
    logic [NUM_PINS-1:0]  r_intr_state;
    logic [NUM_PINS-1:0]  r_intr_en;
    logic [NUM_PINS-1:0]  r_rise_en;
    logic [NUM_PINS-1:0]  r_fall_en;
    logic [NUM_PINS-1:0]  r_lvlhi_en;
    logic [NUM_PINS-1:0]  r_lvllo_en;
    logic [NUM_PINS-1:0]  r_filt_en;
    logic [CNT_WIDTH-1:0] r_filt_th;

    logic [NUM_PINS-1:0]  r_prev;
    logic [NUM_PINS-1:0]  r_stored;
    logic [CNT_WIDTH-1:0] r_cnt   [NUM_PINS];
    logic [CNT_WIDTH-1:0] w_cnt_d [NUM_PINS];
    logic [NUM_PINS-1:0]  r_d_q;

    logic                 w_access;
    logic                 w_wr;
    logic                 w_rd;
    logic [5:0]           w_idx;
    logic [NUM_PINS-1:0]  w_wdat;
    logic                 w_mapped;
    logic [31:0]          w_rdata;
    logic [NUM_PINS-1:0]  w_s;
    logic [NUM_PINS-1:0]  w_f;
    logic [NUM_PINS-1:0]  w_rise;
    logic [NUM_PINS-1:0]  w_fall;
    logic [NUM_PINS-1:0]  w_event;
    logic [NUM_PINS-1:0]  w_w1c;
    logic [NUM_PINS-1:0]  w_test;
    logic                 w_unused;

    assign w_access = PSEL & PENABLE;
    assign w_wr     = w_access & PWRITE;
    assign w_rd     = w_access & ~PWRITE;
    assign w_idx    = PADDR[7:2];
    assign w_wdat   = PWDATA[NUM_PINS-1:0];

    // Input synchroniser (bypassed when the pads are already in the PCLK domain)
    generate
        if (ASYNC_ON != 0) begin : g_sync
            logic [NUM_PINS-1:0] r_sync1;
            logic [NUM_PINS-1:0] r_sync2;
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    r_sync1 <= '0;
                    r_sync2 <= '0;
                end else begin
                    r_sync1 <= gpio_in;
                    r_sync2 <= r_sync1;
                end
            end
            assign w_s = r_sync2;
        end else begin : g_nosync
            assign w_s = gpio_in;
        end
    endgenerate

    // Counter saturates at the threshold, so lowering FILT_TH clamps it on the next cycle
    always_comb begin
        for (int i = 0; i < NUM_PINS; i++) begin
            if (w_s[i] != r_prev[i]) begin
                w_cnt_d[i] = '0;
            end else if (r_cnt[i] >= r_filt_th) begin
                w_cnt_d[i] = r_filt_th;
            end else begin
                w_cnt_d[i] = r_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prev   <= '0;
            r_stored <= '0;
            r_d_q    <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_prev <= w_s;
            r_d_q  <= w_f;
            for (int i = 0; i < NUM_PINS; i++) begin
                r_cnt[i] <= w_cnt_d[i];
                if (w_cnt_d[i] == r_filt_th) begin
                    r_stored[i] <= w_s[i];
                end
            end
        end
    end

    assign w_f     = (r_filt_en & r_stored) | (~r_filt_en & w_s);
    assign w_rise  = ~r_d_q & w_f;
    assign w_fall  = r_d_q & ~w_f;
    assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en)
                   | (w_f & r_lvlhi_en) | (~w_f & r_lvllo_en);
    assign w_w1c   = (w_wr && (w_idx == A_INTR_STATE)) ? w_wdat : '0;
    assign w_test  = (w_wr && (w_idx == A_INTR_TEST)) ? w_wdat : '0;

    // Set terms are OR-ed after the clear so a same-cycle event or test wins over W1C
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_intr_state <= '0;
        end else begin
            r_intr_state <= (r_intr_state & ~w_w1c) | w_event | w_test;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_data_out <= '0;
            r_oe       <= '0;
            r_intr_en  <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_lvlhi_en <= '0;
            r_lvllo_en <= '0;
            r_filt_en  <= '0;
            r_filt_th  <= TH_RST;
        end else if (w_wr) begin
            case (w_idx)
                A_DATA_OUT: r_data_out <= w_wdat;
                A_OUT_SET:  r_data_out <= r_data_out | w_wdat;
                A_OUT_CLR:  r_data_out <= r_data_out & ~w_wdat;
                A_OUT_TGL:  r_data_out <= r_data_out ^ w_wdat;
                A_OE:       r_oe       <= w_wdat;
                A_INTR_EN:  r_intr_en  <= w_wdat;
                A_RISE_EN:  r_rise_en  <= w_wdat;
                A_FALL_EN:  r_fall_en  <= w_wdat;
                A_LVLHI_EN: r_lvlhi_en <= w_wdat;
                A_LVLLO_EN: r_lvllo_en <= w_wdat;
                A_FILT_EN:  r_filt_en  <= w_wdat;
                A_FILT_TH:  r_filt_th  <= PWDATA[CNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

`ifdef GPIO_STRAP_EN
    logic                r_strap_valid;
    logic                r_strap_done;
    logic [NUM_PINS-1:0] r_strap_data;

    // A capture request takes priority over a same-cycle re-arm write
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_strap_valid <= 1'b0;
            r_strap_done  <= 1'b0;
            r_strap_data  <= '0;
        end else if (strap_en && !r_strap_done) begin
            r_strap_valid <= 1'b1;
            r_strap_done  <= 1'b1;
            r_strap_data  <= w_s;
        end else if (w_wr && (w_idx == A_STRAP_CTRL) && PWDATA[0]) begin
            r_strap_valid <= 1'b0;
            r_strap_done  <= 1'b0;
        end
    end

    assign strap_valid = r_strap_valid;
    assign strap_data  = r_strap_data;
    assign w_unused    = ^{PADDR[1:0], PWDATA};
`else
    assign strap_valid = 1'b0;
    assign strap_data  = '0;
    assign w_unused    = ^{PADDR[1:0], PWDATA, strap_en};
`endif

    always_comb begin
        w_mapped = 1'b1;
        w_rdata  = '0;
        case (w_idx)
            A_DATA_IN:    w_rdata = 32'(w_f);
            A_DATA_OUT:   w_rdata = 32'(r_data_out);
            A_OUT_SET,
            A_OUT_CLR,
            A_OUT_TGL,
            A_INTR_TEST:  w_rdata = '0;
            A_OE:         w_rdata = 32'(r_oe);
            A_INTR_STATE: w_rdata = 32'(r_intr_state);
            A_INTR_EN:    w_rdata = 32'(r_intr_en);
            A_RISE_EN:    w_rdata = 32'(r_rise_en);
            A_FALL_EN:    w_rdata = 32'(r_fall_en);
            A_LVLHI_EN:   w_rdata = 32'(r_lvlhi_en);
            A_LVLLO_EN:   w_rdata = 32'(r_lvllo_en);
            A_FILT_EN:    w_rdata = 32'(r_filt_en);
            A_FILT_TH:    w_rdata = 32'(r_filt_th);
`ifdef GPIO_STRAP_EN
            A_STRAP_CTRL: w_rdata = {31'b0, r_strap_valid};
            A_STRAP_DATA: w_rdata = 32'(r_strap_data);
`endif
            default:      w_mapped = 1'b0;
        endcase
    end

    assign PRDATA   = w_rd ? w_rdata : '0;
    assign PSLVERR  = w_access & ~w_mapped;
    assign PREADY   = 1'b1;
    assign gpio_out = r_data_out;
    assign gpio_oe  = r_oe;
    assign irq      = |(r_intr_state & r_intr_en);

endmodule

// File: tb/tb_gpio_apb_gen2.sv
// Bench for gpio_apb_gen2: register vector table, filter timing, interrupt, strap and reset sequences.
module tb_gpio_apb_gen2;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] gpio_in, gpio_out, gpio_oe;
    logic        irq;
    logic        strap_en, strap_valid;
    logic [31:0] strap_data;

    int checks = 0;
    int errors = 0;

    localparam int SYNC = 2;
    localparam int TH   = 4;
`ifdef GPIO_STRAP_EN
    localparam bit STRAP = 1'b1;
`else
    localparam bit STRAP = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] gin;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    localparam int NV = 22;
    vec_t vt [NV];
    exp_t sb_q [$];

    gpio_apb_gen2 dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq),
        .strap_en(strap_en), .strap_valid(strap_valid), .strap_data(strap_data)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic apb_rd(input logic [7:0] addr, input logic [31:0] exp_d, input logic exp_e,
                          input string name);
        exp_t e;
        e.name = name; e.data = exp_d; e.err = exp_e;
        sb_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        e = sb_q.pop_front();
        chk($sformatf("%s_rdata", e.name), PRDATA, e.data);
        chk($sformatf("%s_slverr", e.name), {31'b0, PSLVERR}, {31'b0, e.err});
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data, input logic exp_e,
                          input string name);
        exp_t e;
        e.name = name; e.data = 32'h0; e.err = exp_e;
        sb_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        e = sb_q.pop_front();
        chk($sformatf("%s_slverr", e.name), {31'b0, PSLVERR}, {31'b0, e.err});
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        apb_wr(addr, data, 1'b0, $sformatf("wr_%h", addr));
    endtask

    // Parks the bus in a DATA_IN read and watches bit 0 cycle by cycle around a pad pulse
    task automatic filt_pulse(input int len);
        exp_t e;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h00;
        gpio_in[0] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge PCLK); #1;
            if (n == len) gpio_in[0] = 1'b0;
            e.name = $sformatf("filt_len%0d_cyc%0d", len, n);
            e.data = {31'b0, (len >= TH + 1) && (n >= SYNC + TH + 1) && (n < len + SYNC + TH + 1)};
            e.err  = 1'b0;
            sb_q.push_back(e);
            #2;
            e = sb_q.pop_front();
            chk(e.name, {31'b0, PRDATA[0]}, e.data);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic strap_pulse();
        @(posedge PCLK); #1;
        strap_en = 1'b1;
        @(posedge PCLK); #1;
        strap_en = 1'b0;
    endtask

    initial begin
        //         wr    addr   wdata          gin            exp_rd         err            out           oe
        vt[0]  = '{1'b0, 8'h38, 32'h0,         32'h0,         32'h4,         1'b0,          32'h0,        32'h0};
        vt[1]  = '{1'b0, 8'h18, 32'h0,         32'h0,         32'h0,         1'b0,          32'h0,        32'h0};
        vt[2]  = '{1'b1, 8'h04, 32'h0000_00F0, 32'h0,         32'h0,         1'b0,          32'hF0,       32'h0};
        vt[3]  = '{1'b1, 8'h08, 32'h0000_0001, 32'h0,         32'h0,         1'b0,          32'hF1,       32'h0};
        vt[4]  = '{1'b1, 8'h0C, 32'h0000_0010, 32'h0,         32'h0,         1'b0,          32'hE1,       32'h0};
        vt[5]  = '{1'b1, 8'h10, 32'h0000_0300, 32'h0,         32'h0,         1'b0,          32'h3E1,      32'h0};
        vt[6]  = '{1'b0, 8'h04, 32'h0,         32'h0,         32'h3E1,       1'b0,          32'h3E1,      32'h0};
        vt[7]  = '{1'b0, 8'h10, 32'h0,         32'h0,         32'h0,         1'b0,          32'h3E1,      32'h0};
        vt[8]  = '{1'b1, 8'h14, 32'hFFFF_0000, 32'h0,         32'h0,         1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[9]  = '{1'b0, 8'h14, 32'h0,         32'h0,         32'hFFFF_0000, 1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[10] = '{1'b0, 8'h3C, 32'h0,         32'h0,         32'h0,         !STRAP,        32'h3E1,      32'hFFFF_0000};
        vt[11] = '{1'b0, 8'h44, 32'h0,         32'h0,         32'h0,         1'b1,          32'h3E1,      32'hFFFF_0000};
        vt[12] = '{1'b1, 8'h44, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1,          32'h3E1,      32'hFFFF_0000};
        vt[13] = '{1'b0, 8'h04, 32'h0,         32'h0,         32'h3E1,       1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[14] = '{1'b0, 8'h00, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[15] = '{1'b0, 8'h00, 32'h0,         32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[16] = '{1'b1, 8'h38, 32'h0000_0003, 32'h0,         32'h0,         1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[17] = '{1'b0, 8'h38, 32'h0,         32'h0,         32'h3,         1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[18] = '{1'b1, 8'h38, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[19] = '{1'b0, 8'h38, 32'h0,         32'h0,         32'hF,         1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[20] = '{1'b1, 8'h1C, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0,          32'h3E1,      32'hFFFF_0000};
        vt[21] = '{1'b0, 8'h1C, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0,          32'h3E1,      32'hFFFF_0000};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; gpio_in = '0; strap_en = 1'b0;
        #12;
        chk("rst_gpio_out", gpio_out, 32'h0);
        chk("rst_gpio_oe", gpio_oe, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_pready", {31'b0, PREADY}, 32'h1);
        chk("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_strap_valid", {31'b0, strap_valid}, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;

        for (int i = 0; i < NV; i++) begin
            gpio_in = vt[i].gin;
            repeat (3) @(posedge PCLK);
            #1;
            if (vt[i].wr)
                apb_wr(vt[i].addr, vt[i].wdata, vt[i].exp_err, $sformatf("vec%0d", i));
            else
                apb_rd(vt[i].addr, vt[i].exp_rd, vt[i].exp_err, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_gpio_out", i), gpio_out, vt[i].exp_out);
            chk($sformatf("vec%0d_gpio_oe", i), gpio_oe, vt[i].exp_oe);
        end

        // Glitch filter: 4-cycle pulse is rejected, 5-cycle pulse passes after T+1 cycles
        gpio_in = '0;
        wr(8'h34, 32'h1);
        wr(8'h38, TH);
        repeat (10) @(posedge PCLK);
        filt_pulse(4);
        repeat (10) @(posedge PCLK);
        filt_pulse(5);
        repeat (10) @(posedge PCLK);
        #1;
        wr(8'h34, 32'h0);

        // Edge interrupts
        wr(8'h24, 32'h1);
        wr(8'h28, 32'h2);
        wr(8'h1C, 32'h3);
        gpio_in = 32'h3;
        repeat (4) @(posedge PCLK);
        #1;
        gpio_in = 32'h0;
        repeat (4) @(posedge PCLK);
        #1;
        apb_rd(8'h18, 32'h3, 1'b0, "edge_state");
        chk("edge_irq", {31'b0, irq}, 32'h1);
        wr(8'h18, 32'h1);
        apb_rd(8'h18, 32'h2, 1'b0, "w1c0_state");
        chk("w1c0_irq", {31'b0, irq}, 32'h1);
        wr(8'h18, 32'h2);
        apb_rd(8'h18, 32'h0, 1'b0, "w1c1_state");
        chk("w1c1_irq", {31'b0, irq}, 32'h0);
        wr(8'h24, 32'h0);
        wr(8'h28, 32'h0);

        // Level-high re-asserts over a W1C; level-low likewise captures
        gpio_in = 32'h4;
        repeat (4) @(posedge PCLK);
        #1;
        wr(8'h2C, 32'h4);
        apb_rd(8'h18, 32'h4, 1'b0, "lvlhi_state");
        wr(8'h18, 32'h4);
        apb_rd(8'h18, 32'h4, 1'b0, "lvlhi_after_w1c");
        wr(8'h2C, 32'h0);
        wr(8'h18, 32'h4);
        apb_rd(8'h18, 32'h0, 1'b0, "lvlhi_cleared");
        wr(8'h30, 32'h8);
        wr(8'h30, 32'h0);
        apb_rd(8'h18, 32'h8, 1'b0, "lvllo_state");
        wr(8'h18, 32'h8);
        gpio_in = 32'h0;

        // Interrupt test register, gated only at irq
        wr(8'h1C, 32'h0);
        wr(8'h20, 32'h8000_0000);
        apb_rd(8'h18, 32'h8000_0000, 1'b0, "itest_state");
        chk("itest_irq_masked", {31'b0, irq}, 32'h0);
        wr(8'h1C, 32'h8000_0000);
        chk("itest_irq_enabled", {31'b0, irq}, 32'h1);
        apb_rd(8'h20, 32'h0, 1'b0, "itest_reads0");
        wr(8'h18, 32'h8000_0000);
        chk("itest_irq_cleared", {31'b0, irq}, 32'h0);

        // Strap capture
        gpio_in = 32'hA5;
        repeat (4) @(posedge PCLK);
        #1;
        strap_pulse();
        if (STRAP) begin
            chk("strap1_valid", {31'b0, strap_valid}, 32'h1);
            chk("strap1_data", strap_data, 32'hA5);
            apb_rd(8'h3C, 32'h1, 1'b0, "strap1_ctrl");
            apb_rd(8'h40, 32'hA5, 1'b0, "strap1_reg");
            gpio_in = 32'h5A;
            repeat (4) @(posedge PCLK);
            #1;
            strap_pulse();
            chk("strap2_data_held", strap_data, 32'hA5);
            wr(8'h3C, 32'h1);
            chk("strap_rearm_valid", {31'b0, strap_valid}, 32'h0);
            strap_pulse();
            chk("strap3_valid", {31'b0, strap_valid}, 32'h1);
            apb_rd(8'h40, 32'h5A, 1'b0, "strap3_reg");
        end else begin
            chk("nostrap_valid", {31'b0, strap_valid}, 32'h0);
            chk("nostrap_data", strap_data, 32'h0);
            apb_rd(8'h40, 32'h0, 1'b1, "nostrap_reg");
        end
        gpio_in = 32'h0;

        // Asynchronous reset in the middle of activity
        wr(8'h1C, 32'h1);
        wr(8'h20, 32'h1);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("midrst_gpio_out", gpio_out, 32'h0);
        chk("midrst_gpio_oe", gpio_oe, 32'h0);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        apb_rd(8'h18, 32'h0, 1'b0, "postrst_state");
        apb_rd(8'h38, 32'h4, 1'b0, "postrst_filt_th");
        apb_rd(8'h1C, 32'h0, 1'b0, "postrst_intr_en");
        apb_rd(8'h04, 32'h0, 1'b0, "postrst_data_out");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
